// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches from synchronous instruction memory,
// drives an external one-hot decoder and sequences ALU, PC, jumps and I/O handshakes.
module instr_sequencer #(
    parameter int PC_W   = 8,
    parameter int OPND_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_rd_en,
    input  logic [OPND_W+3:0] imem_data,
    output logic [3:0]        dec_opcode,
    input  logic              dec_load,
    input  logic              dec_add,
    input  logic              dec_bitand,
    input  logic              dec_sub,
    input  logic              dec_input,
    input  logic              dec_output,
    input  logic              dec_jump,
    input  logic              dec_jump_cond,
    input  logic              alu_zero,
    output logic              alu_en,
    output logic [1:0]        alu_sel,
    output logic [OPND_W-1:0] operand,
    output logic              in_req,
    input  logic              in_ack,
    output logic              out_req,
    input  logic              out_ack,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        EXEC    = 3'd3,
        IO_WAIT = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_boundary;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_target;
    logic [OPND_W+3:0]   r_ir;
    logic                r_rd_en;
    logic                r_in_req;
    logic                r_out_req;
    logic                r_busy;
    logic                r_error;
    logic                w_in_req_nxt;
    logic                w_out_req_nxt;
    logic                w_alu_line;
    logic [3:0]          w_line_cnt;

    assign imem_addr  = r_pc;
    assign imem_rd_en = r_rd_en;
    assign dec_opcode = r_ir[OPND_W+3:OPND_W];
    assign operand    = r_ir[OPND_W-1:0];
    assign in_req     = r_in_req;
    assign out_req    = r_out_req;
    assign busy       = r_busy;
    assign error      = r_error;

    assign w_pc_inc   = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_target   = PC_W'(r_ir[OPND_W-1:0]);
    assign w_boundary = run ? FETCH : IDLE;
    assign w_alu_line = dec_load | dec_add | dec_bitand | dec_sub;
    assign w_line_cnt = 4'(dec_load) + 4'(dec_add) + 4'(dec_bitand) + 4'(dec_sub)
                      + 4'(dec_input) + 4'(dec_output) + 4'(dec_jump) + 4'(dec_jump_cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_rd_en   <= 1'b0;
            r_in_req  <= 1'b0;
            r_out_req <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            if (r_state == LATCH)
                r_ir <= imem_data;
            r_rd_en   <= (w_state_nxt == FETCH);
            r_in_req  <= w_in_req_nxt;
            r_out_req <= w_out_req_nxt;
            r_busy    <= (w_state_nxt != IDLE) && (w_state_nxt != ERROR);
            r_error   <= (w_state_nxt == ERROR);
        end
    end

    // The decoder only becomes valid in EXEC (it follows the registered IR), so the
    // ALU strobe and select are decoded from registered state plus those lines.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_in_req_nxt  = r_in_req;
        w_out_req_nxt = r_out_req;
        alu_en        = 1'b0;
        alu_sel       = 2'b00;
        case (r_state)
            IDLE:  if (run) w_state_nxt = FETCH;
            FETCH: w_state_nxt = LATCH;
            LATCH: w_state_nxt = EXEC;
            EXEC: begin
                if (w_line_cnt > 4'd1) begin
                    w_state_nxt = ERROR;
                end else if (dec_input) begin
                    w_in_req_nxt = 1'b1;
                    w_state_nxt  = IO_WAIT;
                end else if (dec_output) begin
                    w_out_req_nxt = 1'b1;
                    w_state_nxt   = IO_WAIT;
                end else if (dec_jump) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = w_boundary;
                end else if (dec_jump_cond) begin
                    w_pc_nxt    = alu_zero ? w_target : w_pc_inc;
                    w_state_nxt = w_boundary;
                end else begin
                    alu_en      = w_alu_line;
                    alu_sel     = dec_sub    ? 2'b11 :
                                  dec_bitand ? 2'b10 :
                                  dec_add    ? 2'b01 : 2'b00;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = w_boundary;
                end
            end
            IO_WAIT: begin
                if ((r_in_req && in_ack) || (r_out_req && out_ack)) begin
                    w_in_req_nxt  = 1'b0;
                    w_out_req_nxt = 1'b0;
                    w_pc_nxt      = w_pc_inc;
                    w_state_nxt   = w_boundary;
                end
            end
            ERROR:   w_state_nxt = ERROR;
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
